// File: rtl/simple_threshold_hls_deadlock_report_unit.sv
// ---------------------------------------------------------------------------
// simple_threshold_hls_deadlock_report_unit
//
// Purpose: consumer side of the simple_threshold deadlock monitor. Confirms
// that the registered block flag has held for CONFIRM_CYCLES consecutive
// cycles, captures a diagnostic record (AXIS channels involved, episode start
// timestamp, event count), delivers it once per episode over a valid/ready
// port and keeps a sticky deadlock flag.
//
// Ports:
//   ap_clk            clock, rising edge
//   ap_rst_n          synchronous active-low reset
//   block             registered block flag from the monitor
//   axis_block_sigs   per-channel block bits, same cycle as block
//   clear             pulse: drop sticky flag, abort/re-arm detection
//   report_valid      report record available
//   report_ready      sink accepts the record
//   report_axis_mask  OR of axis_block_sigs over the confirmation window
//   report_timestamp  ts of the first cycle of the episode
//   report_count      event_count including this episode
//   deadlock          sticky flag, set on confirmation
//   event_count       confirmed episodes, saturating at 255
//
// state  | meaning
// IDLE   | no block seen, waiting for block=1
// ARMED  | counting consecutive block cycles, accumulating mask
// REPORT | record held stable on report_* until accepted
// LOCKED | record delivered, waiting for block to drop before re-arming
// ---------------------------------------------------------------------------
module simple_threshold_hls_deadlock_report_unit #(
    parameter int NUM_AXIS       = 7,
    parameter int CONFIRM_CYCLES = 16,
    parameter int TS_WIDTH       = 32
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                block,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic                clear,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [NUM_AXIS-1:0] report_axis_mask,
    output logic [TS_WIDTH-1:0] report_timestamp,
    output logic [7:0]          report_count,
    output logic                deadlock,
    output logic [7:0]          event_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_REPORT = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(CONFIRM_CYCLES - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NUM_AXIS-1:0] mask_q, mask_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [TS_WIDTH-1:0] start_ts_q, start_ts_d;
    logic [NUM_AXIS-1:0] rpt_mask_q, rpt_mask_d;
    logic [TS_WIDTH-1:0] rpt_ts_q, rpt_ts_d;
    logic [7:0]          rpt_cnt_q, rpt_cnt_d;
    logic                deadlock_q, deadlock_d;
    logic [7:0]          ev_q, ev_d;
    logic [7:0]          ev_next;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            ts_q       <= '0;
            start_ts_q <= '0;
            rpt_mask_q <= '0;
            rpt_ts_q   <= '0;
            rpt_cnt_q  <= '0;
            deadlock_q <= 1'b0;
            ev_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            ts_q       <= ts_d;
            start_ts_q <= start_ts_d;
            rpt_mask_q <= rpt_mask_d;
            rpt_ts_q   <= rpt_ts_d;
            rpt_cnt_q  <= rpt_cnt_d;
            deadlock_q <= deadlock_d;
            ev_q       <= ev_d;
        end
    end

    // Saturating increment; also what report_count shows for this episode.
    assign ev_next = (ev_q == 8'hFF) ? ev_q : ev_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        ts_d       = ts_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
        start_ts_d = start_ts_q;
        rpt_mask_d = rpt_mask_q;
        rpt_ts_d   = rpt_ts_q;
        rpt_cnt_d  = rpt_cnt_q;
        deadlock_d = deadlock_q;
        ev_d       = ev_q;

        if (clear) begin
            // Report fields are left as-is; dropping valid is what discards them.
            state_d    = S_IDLE;
            cnt_d      = '0;
            mask_d     = '0;
            deadlock_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (block) begin
                        state_d    = S_ARMED;
                        cnt_d      = 8'd1;
                        mask_d     = axis_block_sigs;
                        start_ts_d = ts_q;
                    end
                end
                S_ARMED: begin
                    if (!block) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        mask_d  = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        // Window complete: the current cycle's sigs are part of the record.
                        state_d    = S_REPORT;
                        rpt_mask_d = mask_q | axis_block_sigs;
                        rpt_ts_d   = start_ts_q;
                        rpt_cnt_d  = ev_next;
                        ev_d       = ev_next;
                        deadlock_d = 1'b1;
                        cnt_d      = '0;
                        mask_d     = '0;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        mask_d = mask_q | axis_block_sigs;
                    end
                end
                S_REPORT: begin
                    if (report_ready) state_d = S_LOCKED;
                end
                S_LOCKED: begin
                    if (!block) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign report_valid     = (state_q == S_REPORT);
    assign report_axis_mask = rpt_mask_q;
    assign report_timestamp = rpt_ts_q;
    assign report_count     = rpt_cnt_q;
    assign deadlock         = deadlock_q;
    assign event_count      = ev_q;

endmodule

// File: tb/tb_simple_threshold_hls_deadlock_report_unit.sv
// ---------------------------------------------------------------------------
// tb_simple_threshold_hls_deadlock_report_unit
//
// Purpose: self-checking bench for the deadlock report unit. Each scenario
// task drives block/sigs/ready/clear cycle by cycle, pushes the records it
// expects (mask, start ts, count, handshake cycle) into exp_q, and compares
// them against the records accepted at the report port (rx_q).
// Cycle numbers are the bench's own timestamp model, 0 in the first cycle
// after reset release.
// ---------------------------------------------------------------------------
module tb_simple_threshold_hls_deadlock_report_unit;

    typedef struct packed {
        logic [6:0]  mask;
        logic [31:0] ts;
        logic [7:0]  cnt;
        logic [31:0] cyc;
    } rec_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        block = 1'b0;
    logic [6:0]  axis_block_sigs = '0;
    logic        clear = 1'b0;
    logic        report_valid;
    logic        report_ready = 1'b0;
    logic [6:0]  report_axis_mask;
    logic [31:0] report_timestamp;
    logic [7:0]  report_count;
    logic        deadlock;
    logic [7:0]  event_count;

    logic [31:0] tb_ts;
    rec_t        exp_q[$];
    rec_t        rx_q[$];
    rec_t        e, g;
    logic        smp_valid, smp_dl;
    logic [7:0]  smp_ec;
    rec_t        smp_rec;
    int          n_checks = 0;
    int          n_fail = 0;

    simple_threshold_hls_deadlock_report_unit #(
        .NUM_AXIS(7), .CONFIRM_CYCLES(16), .TS_WIDTH(32)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .block(block),
        .axis_block_sigs(axis_block_sigs),
        .clear(clear),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_axis_mask(report_axis_mask),
        .report_timestamp(report_timestamp),
        .report_count(report_count),
        .deadlock(deadlock),
        .event_count(event_count)
    );

    always #5 ap_clk = ~ap_clk;

    // Free-running timestamp as the unit should see it.
    always @(posedge ap_clk) begin
        if (!ap_rst_n) tb_ts <= '0;
        else           tb_ts <= tb_ts + 32'd1;
    end

    function automatic rec_t mk(input logic [6:0] m, input int ts, input int c, input int cy);
        rec_t r;
        r.mask = m;
        r.ts   = 32'(ts);
        r.cnt  = 8'(c);
        r.cyc  = 32'(cy);
        return r;
    endfunction

    // One clock cycle: drive inputs, sample mid-cycle, log any handshake.
    task automatic step(input logic b, input logic [6:0] s, input logic r, input logic c);
        block = b;
        axis_block_sigs = s;
        report_ready = r;
        clear = c;
        @(negedge ap_clk);
        smp_valid = report_valid;
        smp_dl    = deadlock;
        smp_ec    = event_count;
        smp_rec   = mk(report_axis_mask, int'(report_timestamp), int'(report_count), int'(tb_ts));
        if (report_valid && report_ready) rx_q.push_back(smp_rec);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        step(1'b0, 7'h00, 1'b0, 1'b0);
        step(1'b0, 7'h00, 1'b0, 1'b0);
        ap_rst_n = 1'b1;
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        step(1'b1, 7'h7F, 1'b1, 1'b0);
        step(1'b1, 7'h7F, 1'b1, 1'b0);
        n_checks++;
        if ({report_valid, deadlock, event_count, report_axis_mask, report_timestamp, report_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b dl=%b ec=%0d mask=%h ts=%0d cnt=%0d, required all 0",
                     report_valid, deadlock, event_count, report_axis_mask, report_timestamp, report_count);
        end
        ap_rst_n = 1'b1;
        step(1'b0, 7'h00, 1'b1, 1'b0);
        n_checks++;
        if (smp_valid !== 1'b0 || smp_dl !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%b dl=%b, required 0 0", smp_valid, smp_dl);
        end
        rx_q.delete();
    endtask

    task automatic test_confirm();
        do_reset();
        exp_q.push_back(mk(7'h21, 10, 1, 26));
        for (int i = 0; i < 40; i++) begin
            step(i >= 10 && i < 30, (i < 18) ? 7'h01 : 7'h20, 1'b1, 1'b0);
            if (i == 25) begin
                n_checks++;
                if (smp_valid !== 1'b0 || smp_dl !== 1'b0) begin
                    n_fail++;
                    $display("FAIL confirm_early: cyc25 valid=%b dl=%b, required 0 0", smp_valid, smp_dl);
                end
            end
            if (i == 26) begin
                n_checks++;
                if (smp_valid !== 1'b1 || smp_dl !== 1'b1) begin
                    n_fail++;
                    $display("FAIL confirm_rise: cyc26 valid=%b dl=%b, required 1 1", smp_valid, smp_dl);
                end
            end
            if (i == 27) begin
                n_checks++;
                if (smp_valid !== 1'b0 || smp_dl !== 1'b1 || smp_ec !== 8'd1) begin
                    n_fail++;
                    $display("FAIL confirm_fall: cyc27 valid=%b dl=%b ec=%0d, required 0 1 1", smp_valid, smp_dl, smp_ec);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL confirm_missing: no report, required ts=%0d cyc=%0d", e.ts, e.cyc);
            end else begin
                g = rx_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL confirm_rec: got mask=%h ts=%0d cnt=%0d cyc=%0d, required mask=%h ts=%0d cnt=%0d cyc=%0d",
                             g.mask, g.ts, g.cnt, g.cyc, e.mask, e.ts, e.cnt, e.cyc);
                end
            end
        end
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL confirm_extra: %0d extra reports, required 0", rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic test_dropout();
        do_reset();
        exp_q.push_back(mk(7'h02, 21, 1, 37));
        for (int i = 0; i < 45; i++)
            step((i >= 5 && i < 20) || (i >= 21 && i < 37), (i < 20) ? 7'h01 : 7'h02, 1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL dropout_missing: no report, required ts=%0d cyc=%0d", e.ts, e.cyc);
            end else begin
                g = rx_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL dropout_rec: got mask=%h ts=%0d cnt=%0d cyc=%0d, required mask=%h ts=%0d cnt=%0d cyc=%0d",
                             g.mask, g.ts, g.cnt, g.cyc, e.mask, e.ts, e.cnt, e.cyc);
                end
            end
        end
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL dropout_extra: %0d extra reports, required 0", rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic test_backpressure();
        logic b;
        do_reset();
        exp_q.push_back(mk(7'h04, 3, 1, 39));
        for (int i = 0; i < 50; i++) begin
            if (i >= 3 && i < 19) b = 1'b1;
            else if (i >= 19 && i < 39) b = 1'(i % 2);
            else b = 1'b0;
            step(b, (i < 19) ? 7'h04 : 7'(i * 5), i >= 39, 1'b0);
            if (i >= 19 && i < 39) begin
                n_checks++;
                if (smp_valid !== 1'b1 || smp_rec.mask !== 7'h04 || smp_rec.ts !== 32'd3 || smp_rec.cnt !== 8'd1) begin
                    n_fail++;
                    $display("FAIL bp_hold: cyc%0d valid=%b mask=%h ts=%0d cnt=%0d, required 1 04 3 1",
                             i, smp_valid, smp_rec.mask, smp_rec.ts, smp_rec.cnt);
                end
            end
            if (i == 40) begin
                n_checks++;
                if (smp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_fall: cyc40 valid=%b, required 0", smp_valid);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL bp_missing: no report, required ts=%0d cyc=%0d", e.ts, e.cyc);
            end else begin
                g = rx_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL bp_rec: got mask=%h ts=%0d cnt=%0d cyc=%0d, required mask=%h ts=%0d cnt=%0d cyc=%0d",
                             g.mask, g.ts, g.cnt, g.cyc, e.mask, e.ts, e.cnt, e.cyc);
                end
            end
        end
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_extra: %0d extra reports, required 0", rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_q.push_back(mk(7'h08, 2, 1, 18));
        exp_q.push_back(mk(7'h10, 103, 2, 119));
        for (int i = 0; i < 130; i++)
            step((i >= 2 && i < 102) || (i >= 103 && i < 119), (i < 102) ? 7'h08 : 7'h10, 1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL rearm_missing: no report, required ts=%0d cyc=%0d", e.ts, e.cyc);
            end else begin
                g = rx_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL rearm_rec: got mask=%h ts=%0d cnt=%0d cyc=%0d, required mask=%h ts=%0d cnt=%0d cyc=%0d",
                             g.mask, g.ts, g.cnt, g.cyc, e.mask, e.ts, e.cnt, e.cyc);
                end
            end
        end
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL rearm_extra: %0d extra reports, required 0", rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic test_clear_in_report();
        do_reset();
        // The first record is dropped by clear; only the re-detected one arrives.
        exp_q.push_back(mk(7'h40, 23, 2, 39));
        for (int i = 0; i < 50; i++) begin
            step(i >= 4 && i < 45, 7'h40, i >= 30, i == 22);
            if (i == 22) begin
                n_checks++;
                if (smp_valid !== 1'b1 || smp_dl !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clear_pre: cyc22 valid=%b dl=%b, required 1 1", smp_valid, smp_dl);
                end
            end
            if (i == 23) begin
                n_checks++;
                if (smp_valid !== 1'b0 || smp_dl !== 1'b0 || smp_ec !== 8'd1) begin
                    n_fail++;
                    $display("FAIL clear_post: cyc23 valid=%b dl=%b ec=%0d, required 0 0 1", smp_valid, smp_dl, smp_ec);
                end
            end
            if (i == 39) begin
                n_checks++;
                if (smp_dl !== 1'b1 || smp_ec !== 8'd2) begin
                    n_fail++;
                    $display("FAIL clear_redetect: cyc39 dl=%b ec=%0d, required 1 2", smp_dl, smp_ec);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL clear_missing: no report, required ts=%0d cyc=%0d", e.ts, e.cyc);
            end else begin
                g = rx_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL clear_rec: got mask=%h ts=%0d cnt=%0d cyc=%0d, required mask=%h ts=%0d cnt=%0d cyc=%0d",
                             g.mask, g.ts, g.cnt, g.cyc, e.mask, e.ts, e.cnt, e.cyc);
                end
            end
        end
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL clear_extra: %0d extra reports, required 0", rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic test_saturation_and_reset();
        int j;
        int seen_valid;
        do_reset();
        step(1'b0, 7'h00, 1'b1, 1'b0);
        j = 1;
        for (int n = 1; n <= 260; n++) begin
            exp_q.push_back(mk(7'(n), j, (n > 255) ? 255 : n, j + 16));
            for (int i = 0; i < 18; i++) step(i < 16, 7'(n), 1'b1, 1'b0);
            j += 18;
        end
        n_checks++;
        if (event_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_ec: event_count=%0d, required 255", event_count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL sat_missing: no report, required ts=%0d cyc=%0d", e.ts, e.cyc);
            end else begin
                g = rx_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL sat_rec: got mask=%h ts=%0d cnt=%0d cyc=%0d, required mask=%h ts=%0d cnt=%0d cyc=%0d",
                             g.mask, g.ts, g.cnt, g.cyc, e.mask, e.ts, e.cnt, e.cyc);
                end
            end
        end
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL sat_extra: %0d extra reports, required 0", rx_q.size());
            rx_q.delete();
        end
        // Reset in the middle of an ARMED window.
        for (int i = 0; i < 5; i++) step(1'b1, 7'h11, 1'b1, 1'b0);
        ap_rst_n = 1'b0;
        step(1'b1, 7'h11, 1'b1, 1'b0);
        ap_rst_n = 1'b1;
        n_checks++;
        if ({report_valid, deadlock, event_count, report_axis_mask, report_timestamp, report_count} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: valid=%b dl=%b ec=%0d mask=%h ts=%0d cnt=%0d, required all 0",
                     report_valid, deadlock, event_count, report_axis_mask, report_timestamp, report_count);
        end
        seen_valid = 0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 7'h00, 1'b1, 1'b0);
            if (smp_valid) seen_valid++;
        end
        n_checks++;
        if (seen_valid != 0 || rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_noreport: valid cycles=%0d reports=%0d, required 0 0", seen_valid, rx_q.size());
            rx_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_confirm();
        test_dropout();
        test_backpressure();
        test_back_to_back();
        test_clear_in_report();
        test_saturation_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
